// File: rtl/ski_pkg.sv
// Shared types and sizes for the SKI heap loader.
// Word width matches the 130-bit reduction heap word.
package ski_pkg;

  localparam int WORD_W = 130;
  localparam int ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    DONE
  } ld_state_t;

endpackage

// File: rtl/ski_deser.sv
// LSB-first deserializer: shift register plus bit counter.
// o_full flags the transfer that completes a word.
module ski_deser
  import ski_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_shift,
  input  logic         i_bit,
  output logic [W-1:0] o_word,
  output logic         o_full
);

  localparam int CW = $clog2(W);

  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_sr;
  logic          w_last;

  assign w_last = (r_cnt == CW'(W - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (i_shift) begin
      r_sr  <= {i_bit, r_sr[W-1:1]};
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_word = r_sr;
  assign o_full = i_shift && w_last;

endmodule

// File: rtl/ski_heap_loader.sv
// Serial-to-word heap loader: assembles words and writes them
// to consecutive heap addresses over a valid/ready port.
module ski_heap_loader
  import ski_pkg::*;
#(
  parameter int WORD_W = ski_pkg::WORD_W,
  parameter int ADDR_W = ski_pkg::ADDR_W
) (
  input  logic              system1000,
  input  logic              system1000_rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              bit_ready,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] MAXW = {1'b1, {ADDR_W{1'b0}}};

  ld_state_t         r_state;
  logic              r_bit_ready;
  logic              r_wr_valid;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_rem;

  logic              w_shift;
  logic              w_full;
  logic              w_fire;
  logic [ADDR_W:0]   w_num;
  logic [WORD_W-1:0] w_word;

  assign w_shift = bit_valid && r_bit_ready;
  assign w_fire  = r_wr_valid && wr_ready;
  assign w_num   = (num_words > MAXW) ? MAXW : num_words;

  ski_deser #(
    .W(WORD_W)
  ) u_deser (
    .i_clk  (system1000),
    .i_rst  (system1000_rst),
    .i_shift(w_shift),
    .i_bit  (bit_in),
    .o_word (w_word),
    .o_full (w_full)
  );

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      r_state     <= IDLE;
      r_bit_ready <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_addr      <= '0;
      r_rem       <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_addr <= '0;
            r_rem  <= w_num;
            if (w_num == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= SHIFT;
              r_bit_ready <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (w_full) begin
            r_state     <= HOLD;
            r_bit_ready <= 1'b0;
            r_wr_valid  <= 1'b1;
          end
        end
        HOLD: begin
          if (w_fire) begin
            r_wr_valid <= 1'b0;
            r_rem      <= r_rem - 1'b1;
            // Wraps to 0 only after the last write of a full-depth load.
            r_addr     <= r_addr + 1'b1;
            if (r_rem == 1) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state     <= SHIFT;
              r_bit_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bit_ready = r_bit_ready;
  assign wr_valid  = r_wr_valid;
  assign wr_addr   = r_addr;
  assign wr_data   = w_word;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_ski_heap_loader.sv
// Directed bench for ski_heap_loader with a write scoreboard.
// Expected heap writes are queued at stimulus time.
module tb_ski_heap_loader;

  localparam int WW = 130;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic          bit_valid = 1'b0;
  logic          bit_in = 1'b0;
  logic          wr_ready = 1'b0;
  logic          bit_ready;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [WW-1:0] wr_data;
  logic          busy;
  logic          done;

  int total = 0;
  int bad = 0;
  int n_wr = 0;
  logic [AW+WW-1:0] q[$];

  ski_heap_loader dut (
    .system1000    (clk),
    .system1000_rst(rst),
    .start         (start),
    .num_words     (num_words),
    .bit_valid     (bit_valid),
    .bit_in        (bit_in),
    .bit_ready     (bit_ready),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [159:0] got,
                     input logic [159:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wr_valid) begin
      chk("hold_bit_ready", 160'(bit_ready), 160'(0));
      if (wr_ready) begin
        n_wr++;
        chk("q_avail", 160'(q.size() != 0), 160'(1));
        if (q.size() != 0)
          chk("write", 160'({wr_addr, wr_data}), 160'(q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WW-1:0] rnd_word();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[WW-1:0];
  endfunction

  task automatic start_load(input int n);
    num_words = (AW+1)'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bits(input logic [WW-1:0] w, input bit gaps,
                           input int lo, input int hi);
    int k;
    int guard;
    k = lo;
    guard = 0;
    while (k < hi && guard < 4000) begin
      bit_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bit_in = w[k];
      @(negedge clk);
      if (bit_valid && bit_ready) k++;
      tick();
      guard++;
    end
    chk("bits_accepted", 160'(k), 160'(hi));
  endtask

  initial begin
    logic [WW-1:0] w;
    logic [WW-1:0] ws[4];
    int n0;

    // reset and idle
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("idle", 160'({bit_ready, wr_valid, busy, done, wr_addr, wr_data}),
          160'(0));
    end
    tick();

    // single word, k%3 pattern
    for (int k = 0; k < WW; k++) w[k] = (k % 3 == 0);
    wr_ready = 1'b1;
    n0 = n_wr;
    start_load(1);
    q.push_back({AW'(0), w});
    send_bits(w, 1'b0, 0, WW);
    @(negedge clk);
    chk("p1_valid_latency", 160'(wr_valid), 160'(1));
    @(negedge clk);
    chk("p1_done", 160'({done, busy}), 160'(2'b10));
    @(negedge clk);
    chk("p1_done_gone", 160'(done), 160'(0));
    chk("p1_nwr", 160'(n_wr - n0), 160'(1));
    bit_valid = 1'b0;
    tick();

    // three words with stalled write port
    wr_ready = 1'b0;
    n0 = n_wr;
    start_load(3);
    for (int i = 0; i < 3; i++) begin
      w = rnd_word();
      q.push_back({AW'(i), w});
      send_bits(w, 1'b0, 0, WW);
      repeat (10) begin
        @(negedge clk);
        chk("stall_valid", 160'({wr_valid, wr_addr}), 160'({1'b1, AW'(i)}));
        tick();
      end
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
    end
    @(negedge clk);
    chk("p3_done", 160'(done), 160'(1));
    chk("p3_nwr", 160'(n_wr - n0), 160'(3));
    bit_valid = 1'b0;
    tick();

    // zero-length load
    wr_ready = 1'b1;
    n0 = n_wr;
    num_words = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("z_done", 160'({done, busy}), 160'(2'b10));
    @(negedge clk);
    chk("z_after", 160'({done, busy}), 160'(0));
    chk("z_nwr", 160'(n_wr - n0), 160'(0));
    tick();

    // four words gap-free, then the same four with random gaps
    for (int i = 0; i < 4; i++) ws[i] = rnd_word();
    for (int g = 0; g < 2; g++) begin
      n0 = n_wr;
      start_load(4);
      for (int i = 0; i < 4; i++) begin
        q.push_back({AW'(i), ws[i]});
        send_bits(ws[i], g == 1, 0, WW);
      end
      @(negedge clk);
      @(negedge clk);
      chk("p4_done", 160'(done), 160'(1));
      chk("p4_nwr", 160'(n_wr - n0), 160'(4));
      bit_valid = 1'b0;
      tick();
    end

    // reset in the middle of word 2
    n0 = n_wr;
    start_load(3);
    for (int i = 0; i < 2; i++) begin
      ws[i] = rnd_word();
      q.push_back({AW'(i), ws[i]});
      send_bits(ws[i], 1'b0, 0, WW);
    end
    send_bits(rnd_word(), 1'b0, 0, 60);
    bit_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out", 160'({bit_ready, wr_valid, busy, done, wr_addr, wr_data}),
        160'(0));
    chk("rst_nwr", 160'(n_wr - n0), 160'(2));
    repeat (5) tick();
    chk("rst_nwr_after", 160'(n_wr - n0), 160'(2));

    // fresh load; start during SHIFT must not change remaining
    n0 = n_wr;
    start_load(2);
    ws[0] = rnd_word();
    ws[1] = rnd_word();
    q.push_back({AW'(0), ws[0]});
    q.push_back({AW'(1), ws[1]});
    send_bits(ws[0], 1'b0, 0, 10);
    bit_valid = 1'b0;
    num_words = 11'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_bits(ws[0], 1'b0, 10, WW);
    send_bits(ws[1], 1'b0, 0, WW);
    @(negedge clk);
    @(negedge clk);
    chk("re_done", 160'(done), 160'(1));
    chk("re_nwr", 160'(n_wr - n0), 160'(2));
    bit_valid = 1'b0;
    repeat (10) tick();
    chk("q_empty", 160'(q.size()), 160'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
